// File: rtl/sp_ram_pkg.sv
// Shared widths and word/address types for the 16x8 single-port RAM.
// Pulled in by the RAM and by anything that drives it.
package sp_ram_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage : sp_ram_pkg

// File: rtl/sp_ram_16x8.sv
// Synchronous single-port RAM with a registered, write-first read port.
// Reset clears only the output register; stored words survive it.
module sp_ram_16x8 #(
    parameter int DATA_WIDTH = sp_ram_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = sp_ram_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_q;

    // Array and output register share one process so the tools map it onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= data;
        end
        if (rst) begin
            r_q <= '0;
        end else if (we) begin
            r_q <= data;
        end else begin
            r_q <= r_mem[addr];
        end
    end

    assign q = r_q;

endmodule : sp_ram_16x8

// File: tb/tb_sp_ram_16x8.sv
// Directed bench for sp_ram_16x8: reset, write-first, fill/readback,
// read latency and reset-while-running behaviour.
module tb_sp_ram_16x8;
    import sp_ram_pkg::*;

    logic  clk;
    logic  rst;
    data_t data;
    addr_t addr;
    logic  we;
    data_t q;

    int    total;
    int    bad;
    data_t model [DEPTH];

    sp_ram_16x8 dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .addr (addr),
        .we   (we),
        .q    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are changed at a negedge; waiting for the next negedge spans one rising edge.
    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; addr = '0; data = '0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            total++;
            if (q !== 8'h00) begin
                bad++;
                $display("FAIL reset_q cycle=%0d got=%h want=00", i, q);
            end
        end
        rst = 1'b0; addr = 4'd0;
        cycle();
        $display("reset: q held 00 for 2 cycles");
    endtask

    task automatic test_initial_write();
        we = 1'b1; addr = 4'd0; data = 8'hFF;
        cycle();
        model[0] = 8'hFF;
        total++;
        if (q !== 8'hFF) begin
            bad++;
            $display("FAIL write_first_addr0 got=%h want=ff", q);
        end
        we = 1'b0;
        cycle();
        total++;
        if (q !== 8'hFF) begin
            bad++;
            $display("FAIL read_addr0 got=%h want=ff", q);
        end
        $display("initial write: addr=0 data=ff q=%h", q);
    endtask

    task automatic test_fill();
        for (int a = 0; a < DEPTH; a++) begin
            data_t d;
            d = data_t'($urandom_range(0, 255));
            we = 1'b1; addr = addr_t'(a); data = d;
            model[a] = d;
            for (int c = 0; c < 2; c++) begin
                cycle();
                total++;
                if (q !== d) begin
                    bad++;
                    $display("FAIL fill addr=%0d cycle=%0d got=%h want=%h", a, c, q, d);
                end
            end
            $display("fill: addr=%0d data=%h q=%h", a, d, q);
        end
        we = 1'b0;
    endtask

    task automatic test_readback();
        we = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            addr = addr_t'(a);
            for (int c = 0; c < 2; c++) begin
                cycle();
                total++;
                if (q !== model[a]) begin
                    bad++;
                    $display("FAIL readback addr=%0d cycle=%0d got=%h want=%h", a, c, q, model[a]);
                end
            end
            $display("readback: addr=%0d q=%h", a, q);
        end
    endtask

    task automatic test_latency();
        we = 1'b0; addr = 4'd3;
        cycle();
        total++;
        if (q !== model[3]) begin
            bad++;
            $display("FAIL latency_addr3 got=%h want=%h", q, model[3]);
        end
        addr = 4'd7;
        #2;
        total++;
        if (q !== model[3]) begin
            bad++;
            $display("FAIL latency_hold got=%h want=%h", q, model[3]);
        end
        cycle();
        total++;
        if (q !== model[7]) begin
            bad++;
            $display("FAIL latency_addr7 got=%h want=%h", q, model[7]);
        end
        $display("latency: addr 3->7 mid-cycle, q=%h", q);
    endtask

    task automatic test_reset_mid();
        we = 1'b1; addr = 4'd5; data = 8'hA5;
        cycle();
        we = 1'b0; rst = 1'b1;
        cycle();
        total++;
        if (q !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset_q got=%h want=00", q);
        end
        rst = 1'b0; addr = 4'd5;
        cycle();
        total++;
        if (q !== 8'hA5) begin
            bad++;
            $display("FAIL retain_addr5 got=%h want=a5", q);
        end
        $display("reset mid: addr5 retained q=%h", q);

        rst = 1'b1; we = 1'b1; addr = 4'd6; data = 8'h3C;
        cycle();
        total++;
        if (q !== 8'h00) begin
            bad++;
            $display("FAIL reset_with_write got=%h want=00", q);
        end
        rst = 1'b0; we = 1'b0; data = 8'h00;
        cycle();
        total++;
        if (q !== 8'h3C) begin
            bad++;
            $display("FAIL write_under_reset_addr6 got=%h want=3c", q);
        end
        $display("reset with write: addr6 q=%h", q);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        we    = 1'b0;
        addr  = '0;
        data  = '0;
        @(negedge clk);
        test_reset();
        test_initial_write();
        test_fill();
        test_readback();
        test_latency();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sp_ram_16x8
